// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the Y86 data-memory controller: icodes, FSM states,
// memory op kinds and the icode decode helpers.
package data_mem_ctrl_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_IOPQ   = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_READ,
      OP_WRITE
   } op_e;

   function automatic op_e decode_op(input logic [3:0] icode);
      op_e op;
      unique case (1'b1)
         icode == I_RMMOVQ,
         icode == I_PUSHQ,
         icode == I_CALL:   op = OP_WRITE;
         icode == I_MRMOVQ,
         icode == I_RET,
         icode == I_POPQ:   op = OP_READ;
         default:           op = OP_NONE;
      endcase
      return op;
   endfunction

   // Stack pops address memory through valA, everything else via valE.
   function automatic logic addr_from_a(input logic [3:0] icode);
      return (icode == I_RET) || (icode == I_POPQ);
   endfunction

   // CALL stores the return address, other writes store valA.
   function automatic logic data_from_p(input logic [3:0] icode);
      return icode == I_CALL;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// dmem_array: byte-addressed store, DATA_W-wide little-endian read port,
// synchronous write port (clk, we, addr, wdata, rdata). No reset.
module dmem_array #(
   parameter int DEPTH_BYTES = 1024,
   parameter int DATA_W      = 64,
   parameter int AW          = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int NB = DATA_W / 8;

   logic [7:0] mem [DEPTH_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < NB; k++) begin
            mem[addr + AW'(k)] <= wdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NB; k++) begin
         rdata[8*k +: 8] = mem[addr + AW'(k)];
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: Y86 memory-stage controller. valid/ready request in
// (icode, valE, valA, valP), one-cycle resp strobe out with valM and
// dmem_error. Optional DMEM_ALIGN_CHECK_EN flags misaligned addresses.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int DATA_W      = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        icode_i,
   input  logic [DATA_W-1:0] valE_i,
   input  logic [DATA_W-1:0] valA_i,
   input  logic [DATA_W-1:0] valP_i,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] valM_o,
   output logic              dmem_error_o
);

   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam logic [DATA_W-1:0] LIMIT = DATA_W'(DEPTH_BYTES - NB);
   localparam logic NO_WAIT = (WAIT_CYCLES == 0);

   state_e            state;
   logic [3:0]        cnt;
   op_e               op_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] val_m_q;
   logic              err_q;

   logic              idle;
   logic              accept;
   op_e               req_op;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   op_e               cur_op;
   logic [DATA_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic              bad;
   logic              enter_resp;
   logic              we;
   logic [DATA_W-1:0] rdata;

   assign idle   = (state == ST_IDLE);
   assign accept = req_valid_i && idle;

   assign req_op    = decode_op(icode_i);
   assign req_addr  = addr_from_a(icode_i) ? valA_i : valE_i;
   assign req_wdata = data_from_p(icode_i) ? valP_i : valA_i;

   // With no wait states the access happens on the accept edge itself,
   // before the request registers are loaded, so use the live request.
   assign cur_op    = idle ? req_op    : op_q;
   assign cur_addr  = idle ? req_addr  : addr_q;
   assign cur_wdata = idle ? req_wdata : wdata_q;

   always_comb begin
      bad = (cur_addr > LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
      bad = bad || ((cur_addr % DATA_W'(NB)) != '0);
`endif
   end

   assign enter_resp = (accept && (req_op == OP_NONE || NO_WAIT))
                    || (state == ST_WAIT && cnt == 4'd0);
   assign we = enter_resp && (cur_op == OP_WRITE) && !bad;

   dmem_array #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .DATA_W      (DATA_W),
      .AW          (AW)
   ) u_array (
      .clk   (clk_i),
      .we    (we),
      .addr  (cur_addr[AW-1:0]),
      .wdata (cur_wdata),
      .rdata (rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         op_q    <= OP_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         val_m_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (enter_resp) begin
            err_q   <= (cur_op != OP_NONE) && bad;
            val_m_q <= (cur_op == OP_READ && !bad) ? rdata : '0;
         end
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (enter_resp) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) state <= ST_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o  = idle;
   assign resp_valid_o = (state == ST_RESP);
   assign valM_o       = val_m_q;
   assign dmem_error_o = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance,
// table-driven requests with a response scoreboard plus corner sequences.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid0 = 1'b0;
   logic        valid3 = 1'b0;
   logic [3:0]  icode = 4'h1;
   logic [63:0] val_e = '0;
   logic [63:0] val_a = '0;
   logic [63:0] val_p = '0;

   logic        ready0, resp0, err0;
   logic        ready3, resp3, err3;
   logic [63:0] valm0, valm3;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_BYTES(1024), .DATA_W(64), .WAIT_CYCLES(0)) dut0 (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (valid0),
      .req_ready_o  (ready0),
      .icode_i      (icode),
      .valE_i       (val_e),
      .valA_i       (val_a),
      .valP_i       (val_p),
      .resp_valid_o (resp0),
      .valM_o       (valm0),
      .dmem_error_o (err0)
   );

   data_mem_ctrl #(.DEPTH_BYTES(1024), .DATA_W(64), .WAIT_CYCLES(3)) dut3 (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (valid3),
      .req_ready_o  (ready3),
      .icode_i      (icode),
      .valE_i       (val_e),
      .valA_i       (val_a),
      .valP_i       (val_p),
      .resp_valid_o (resp3),
      .valM_o       (valm3),
      .dmem_error_o (err3)
   );

   typedef struct {
      int          sel;
      logic [3:0]  icode;
      logic [63:0] e;
      logic [63:0] a;
      logic [63:0] p;
      logic [63:0] exp_m;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [63:0] m;
      logic        err;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic resp_of(input int s);
      return (s == 0) ? resp0 : resp3;
   endfunction

   function automatic logic ready_of(input int s);
      return (s == 0) ? ready0 : ready3;
   endfunction

   task automatic add(input int s, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p,
                      input logic [63:0] m, input logic er, input int lat);
      vec_t v;
      v.sel = s; v.icode = ic; v.e = e; v.a = a; v.p = p;
      v.exp_m = m; v.exp_err = er; v.exp_lat = lat;
      vecs.push_back(v);
   endtask

   task automatic run_req(input vec_t v);
      exp_t x;
      int lat;
      @(negedge clk);
      icode = v.icode; val_e = v.e; val_a = v.a; val_p = v.p;
      chk("ready_before_req", 64'(ready_of(v.sel)), 64'd1);
      if (v.sel == 0) valid0 = 1'b1;
      else            valid3 = 1'b1;
      sb.push_back('{v.exp_m, v.exp_err, v.exp_lat});
      @(posedge clk);
      #1;
      valid0 = 1'b0;
      valid3 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_of(v.sel) && lat < 32);
      if (!resp_of(v.sel)) chk("resp_timeout", 64'd0, 64'd1);
      x = sb.pop_front();
      chk("valM", (v.sel == 0) ? valm0 : valm3, x.m);
      chk("dmem_error", 64'((v.sel == 0) ? err0 : err3), 64'(x.err));
      chk("latency", 64'(lat), 64'(x.lat));
   endtask

   initial begin
      int lat;
      int low;
      int extra;
      logic [63:0] mis_m;
      logic        mis_e;
      vec_t v;

`ifdef DMEM_ALIGN_CHECK_EN
      mis_m = 64'h0; mis_e = 1'b1;
`else
      mis_m = 64'h0607_0811_2233_4455; mis_e = 1'b0;
`endif

      // sel icode   valE   valA   valP   exp valM   err lat
      add(0, 4'h4, 64'h10, 64'h1122334455667788, 0, 0, 0, 1);
      add(0, 4'h5, 64'h10, 0, 0, 64'h1122334455667788, 0, 1);
      add(0, 4'h4, 64'h18, 64'h0102030405060708, 0, 0, 0, 1);
      add(0, 4'h5, 64'h13, 0, 0, mis_m, mis_e, 1);
      add(0, 4'h5, 64'h3F9, 0, 0, 0, 1, 1);
      add(0, 4'h4, 64'h3F8, 64'hCAFEBABEDEADBEEF, 0, 0, 0, 1);
      add(0, 4'h4, 64'hFFFFFFFFFFFFFFF8, 64'hDEADDEADDEADDEAD, 0, 0, 1, 1);
      add(0, 4'h5, 64'h3F8, 0, 0, 64'hCAFEBABEDEADBEEF, 0, 1);
      add(0, 4'h8, 64'h100, 64'h55, 64'h2A, 0, 0, 1);
      add(0, 4'h9, 64'h300, 64'h100, 0, 64'h2A, 0, 1);
      add(0, 4'hC, 64'h10, 64'h10, 0, 0, 0, 1);
      add(0, 4'h1, 64'h3FF, 0, 0, 0, 0, 1);
      add(0, 4'hA, 64'h200, 64'h0123456789ABCDEF, 0, 0, 0, 1);
      add(0, 4'hB, 64'h10, 64'h200, 0, 64'h0123456789ABCDEF, 0, 1);
      add(0, 4'h5, 64'h10, 0, 0, 64'h1122334455667788, 0, 1);
      add(3, 4'h4, 64'h20, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0, 4);
      add(3, 4'h5, 64'h20, 0, 0, 64'hA5A5A5A5A5A5A5A5, 0, 4);
      add(3, 4'hC, 64'h20, 0, 0, 0, 0, 1);

      repeat (3) @(negedge clk);
      chk("rst_ready0", 64'(ready0), 64'd1);
      chk("rst_resp0", 64'(resp0), 64'd0);
      chk("rst_valm0", valm0, 64'd0);
      chk("rst_err0", 64'(err0), 64'd0);
      chk("rst_ready3", 64'(ready3), 64'd1);
      chk("rst_resp3", 64'(resp3), 64'd0);
      chk("rst_valm3", valm3, 64'd0);
      chk("rst_err3", 64'(err3), 64'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_req(vecs[i]);

      // Request held high through WAIT must be ignored, not queued.
      @(negedge clk);
      icode = 4'h5; val_e = 64'h20; val_a = 0;
      valid3 = 1'b1;
      @(posedge clk);
      #1;
      icode = 4'h4; val_e = 64'h20; val_a = 64'h0;
      lat = 0;
      low = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!ready3) low++;
      end while (!resp3 && lat < 32);
      valid3 = 1'b0;
      chk("wait_latency", 64'(lat), 64'd4);
      chk("wait_ready_low", 64'(low), 64'd4);
      chk("wait_valm", valm3, 64'hA5A5A5A5A5A5A5A5);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp3) extra++;
      end
      chk("wait_no_extra_resp", 64'(extra), 64'd0);

      // Reset mid-WAIT aborts the write and clears outputs at once.
      @(negedge clk);
      icode = 4'h4; val_e = 64'h20; val_a = 64'h5A5A5A5A5A5A5A5A;
      valid3 = 1'b1;
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_resp", 64'(resp3), 64'd0);
      chk("arst_valm", valm3, 64'd0);
      chk("arst_err", 64'(err3), 64'd0);
      chk("arst_ready", 64'(ready3), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      v.sel = 3; v.icode = 4'h5; v.e = 64'h20; v.a = 0; v.p = 0;
      v.exp_m = 64'hA5A5A5A5A5A5A5A5; v.exp_err = 1'b0; v.exp_lat = 4;
      run_req(v);
      v.sel = 0; v.icode = 4'h5; v.e = 64'h10;
      v.exp_m = 64'h1122334455667788; v.exp_lat = 1;
      run_req(v);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
